// File: rtl/imm_encoder_if.sv
// Request/result bundle between a requester and imm_encoder.
// The requester owns start/value; the encoder owns busy/done and the result fields.
interface imm_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        fail;
  logic        inv;
  logic [11:0] imm12;

  modport master (
    output start, value,
    input  busy, done, fail, inv, imm12
  );

  modport slave (
    input  start, value,
    output busy, done, fail, inv, imm12
  );
endinterface

// File: rtl/imm_encoder.sv
// Sequential search for a rotated-8-bit immediate encoding of a 32-bit constant,
// optionally retrying on the inverted constant (MVN form).
module imm_encoder #(
  parameter bit TRY_INVERTED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  imm_encoder_if.slave       bus,
  output logic [1:0]         dbg_state
);

  // Handshake: start is accepted only in IDLE, with value sampled on that same
  // edge. busy is high for the whole search; done pulses for one cycle when the
  // result is ready. fail/inv/imm12 are valid with done and held until the next
  // accepted start. start seen while busy or done is dropped, never queued.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] operand_q, operand_d;
  logic [3:0]  rot_q, rot_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        inv_q, inv_d;
  logic [11:0] imm12_q, imm12_d;

  logic [5:0]  shamt;
  logic [31:0] candidate;
  logic        hit;

  // A shift by 32 yields zero, so rot=0 collapses to the unrotated operand.
  assign shamt     = {1'b0, rot_q, 1'b0};
  assign candidate = (operand_q << shamt) | (operand_q >> (6'd32 - shamt));
  assign hit       = (candidate[31:8] == 24'd0);

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    rot_d     = rot_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    inv_d     = inv_q;
    imm12_d   = imm12_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          operand_d = bus.value;
          rot_d     = 4'd0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          inv_d     = 1'b0;
          imm12_d   = 12'h000;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          imm12_d = {rot_q, candidate[7:0]};
          inv_d   = pass_q;
          state_d = DONE;
        end else if (rot_q != 4'd15) begin
          rot_d = rot_q + 4'd1;
        end else if (!pass_q && TRY_INVERTED) begin
          operand_d = ~operand_q;
          pass_d    = 1'b1;
          rot_d     = 4'd0;
        end else begin
          fail_d  = 1'b1;
          imm12_d = 12'h000;
          inv_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      operand_q <= 32'd0;
      rot_q     <= 4'd0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      inv_q     <= 1'b0;
      imm12_q   <= 12'h000;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      rot_q     <= rot_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      inv_q     <= inv_d;
      imm12_q   <= imm12_d;
    end
  end

  assign bus.busy  = (state_q == SEARCH);
  assign bus.done  = (state_q == DONE);
  assign bus.fail  = fail_q;
  assign bus.inv   = inv_q;
  assign bus.imm12 = imm12_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder: one instance with the inverted pass
// enabled, one without, checked against hand-computed results and done cycles.
module tb_imm_encoder;

  logic clk;
  logic reset;

  imm_encoder_if bus_a ();
  imm_encoder_if bus_b ();
  logic [1:0] dbg_a, dbg_b;

  imm_encoder #(.TRY_INVERTED(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .dbg_state(dbg_a)
  );
  imm_encoder #(.TRY_INVERTED(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .dbg_state(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // selected-instance views so one driver task serves both DUTs
  logic sel;
  logic s_busy, s_done, s_fail, s_inv;
  logic [11:0] s_imm12;
  assign s_busy  = sel ? bus_b.busy  : bus_a.busy;
  assign s_done  = sel ? bus_b.done  : bus_a.done;
  assign s_fail  = sel ? bus_b.fail  : bus_a.fail;
  assign s_inv   = sel ? bus_b.inv   : bus_a.inv;
  assign s_imm12 = sel ? bus_b.imm12 : bus_a.imm12;

  task automatic drive(input logic st, input logic [31:0] v);
    if (sel) begin
      bus_b.start = st; bus_b.value = v;
    end else begin
      bus_a.start = st; bus_a.value = v;
    end
  endtask

  // One request: start in cycle 0, then watch for done within a bounded budget.
  task automatic run_vec(input string tag, input logic which, input logic [31:0] v,
                         input int exp_cyc, input logic [11:0] exp_imm,
                         input logic exp_inv, input logic exp_fail);
    int cyc;
    int busy_cnt;
    bit found;
    sel = which;
    @(posedge clk); #1;
    drive(1'b1, v);
    @(posedge clk); #1;
    drive(1'b0, $urandom);
    cyc = 1; busy_cnt = 0; found = 0;
    while (!found && cyc < 40) begin
      @(negedge clk);
      if (s_done) found = 1;
      else begin
        if (s_busy) busy_cnt++;
        cyc++;
      end
    end
    check_val({tag, "_found"}, 32'(found), 32'd1);
    check_val({tag, "_cycle"}, cyc, exp_cyc);
    check_val({tag, "_busy_cnt"}, busy_cnt, exp_cyc - 1);
    check_val({tag, "_busy_in_done"}, 32'(s_busy), 32'd0);
    check_val({tag, "_imm12"}, 32'(s_imm12), 32'(exp_imm));
    check_val({tag, "_inv"}, 32'(s_inv), 32'(exp_inv));
    check_val({tag, "_fail"}, 32'(s_fail), 32'(exp_fail));
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 32'(s_done), 32'd0);
    check_val({tag, "_imm12_hold"}, 32'(s_imm12), 32'(exp_imm));
  endtask

  int done_seen;

  initial begin
    sel = 1'b0;
    bus_a.start = 1'b0; bus_a.value = 32'd0;
    bus_b.start = 1'b0; bus_b.value = 32'd0;
    reset = 1'b1;
    // reset wins over start
    @(posedge clk); #1;
    bus_a.start = 1'b1; bus_a.value = 32'h000000FF;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_state", 32'(dbg_a), 32'd0);
    check_val("rst_busy", 32'(bus_a.busy), 32'd0);
    check_val("rst_done", 32'(bus_a.done), 32'd0);
    check_val("rst_outs", {19'd0, bus_a.fail, bus_a.inv, bus_a.imm12}, 32'd0);
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("idle_hold", {19'd0, bus_a.busy, bus_a.done, bus_a.imm12}, 32'd0);

    run_vec("v_ff",     1'b0, 32'h000000FF, 2,  12'h0FF, 1'b0, 1'b0);
    run_vec("v_zero",   1'b0, 32'h00000000, 2,  12'h000, 1'b0, 1'b0);
    run_vec("v_f00f",   1'b0, 32'hF000000F, 4,  12'h2FF, 1'b0, 1'b0);
    run_vec("v_3fc00",  1'b0, 32'h0003FC00, 13, 12'hBFF, 1'b0, 1'b0);
    run_vec("v_104",    1'b0, 32'h00000104, 17, 12'hF41, 1'b0, 1'b0);
    run_vec("v_inv",    1'b0, 32'hFFFFFF00, 18, 12'h0FF, 1'b1, 1'b0);
    run_vec("v_101",    1'b0, 32'h00000101, 33, 12'h000, 1'b0, 1'b1);
    run_vec("b_inv",    1'b1, 32'hFFFFFF00, 17, 12'h000, 1'b0, 1'b1);
    run_vec("b_3fc00",  1'b1, 32'h0003FC00, 13, 12'hBFF, 1'b0, 1'b0);

    // idle outputs hold the last result
    repeat (3) @(negedge clk);
    check_val("b_idle_hold_fail", 32'(bus_b.fail), 32'd0);
    check_val("b_idle_hold_imm", 32'(bus_b.imm12), 32'hBFF);

    // re-start mid-search is ignored; reset in cycle 6 aborts with no done
    sel = 1'b0;
    done_seen = 0;
    @(posedge clk); #1;
    bus_a.start = 1'b1; bus_a.value = 32'h00000101;   // cycle 0
    @(posedge clk); #1;
    bus_a.start = 1'b0; bus_a.value = 32'h000000FF;   // cycle 1
    for (int c = 1; c < 5; c++) begin
      @(negedge clk); if (bus_a.done) done_seen++;
      @(posedge clk); #1;
    end
    bus_a.start = 1'b1;                               // cycle 5
    @(negedge clk); if (bus_a.done) done_seen++;
    check_val("restart_busy", 32'(bus_a.busy), 32'd1);
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    reset = 1'b1;                                     // cycle 6
    @(negedge clk); if (bus_a.done) done_seen++;
    @(posedge clk); #1;
    reset = 1'b0;                                     // cycle 7
    @(negedge clk); if (bus_a.done) done_seen++;
    check_val("abort_state", 32'(dbg_a), 32'd0);
    check_val("abort_outs", {18'd0, bus_a.busy, bus_a.done, bus_a.fail, bus_a.inv, bus_a.imm12}, 32'd0);
    repeat (30) begin
      @(negedge clk); if (bus_a.done) done_seen++;
    end
    check_val("abort_no_done", done_seen, 0);
    run_vec("post_abort_ff", 1'b0, 32'h000000FF, 2, 12'h0FF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
